// File: rtl/mux16_rr_arbiter.sv
// mux16_rr_arbiter: 16-requester round-robin arbiter with a per-owner hold limit,
// driving a 16:1 data mux. Grant, select and valid are registered; the mux
// output follows the selected data lane combinationally.
module mux16_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic [15:0] d,
  output logic [15:0] gnt,
  output logic        gnt_valid,
  output logic [3:0]  sel,
  output logic        out
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Hold counter value on the owner's last permitted cycle.
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t      state_reg;
  logic [3:0]  ptr_reg;
  logic [7:0]  hold_reg;

  logic [3:0]  search_base;
  logic [15:0] rot_req;
  logic        found;
  logic [3:0]  found_off;
  logic [3:0]  winner;
  logic        owner_req;
  logic        release_now;

  // In GRANT the only search that matters is the release search, which starts
  // just past the current owner (that value also becomes the new pointer).
  // In IDLE the search starts at the stored pointer.
  assign search_base = (state_reg == GRANT) ? (sel + 4'd1) : ptr_reg;

  // Rotate the request vector so that bit 0 is the highest-priority requester.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_rot
      assign rot_req[gi] = req[4'(search_base + 4'(gi))];
    end
  endgenerate

  // Priority encode the rotated vector: lowest set bit wins.
  always_comb begin
    found     = 1'b0;
    found_off = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (rot_req[i]) begin
        found     = 1'b1;
        found_off = 4'(i);
      end
    end
  end

  assign winner      = search_base + found_off;
  assign owner_req   = req[sel];
  assign release_now = !owner_req || (hold_reg == HOLD_LAST);

  // Arbitration state machine; all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= 4'd0;
      hold_reg  <= 8'd0;
      sel       <= 4'd0;
      gnt       <= 16'd0;
      gnt_valid <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (found) begin
            state_reg <= GRANT;
            sel       <= winner;
            gnt       <= 16'd1 << winner;
            gnt_valid <= 1'b1;
            hold_reg  <= 8'd0;
          end
        end
        GRANT: begin
          if (release_now) begin
            ptr_reg <= sel + 4'd1;
            if (found) begin
              // Back-to-back handover (possibly to the same owner if alone).
              sel       <= winner;
              gnt       <= 16'd1 << winner;
              gnt_valid <= 1'b1;
              hold_reg  <= 8'd0;
            end else begin
              state_reg <= IDLE;
              gnt       <= 16'd0;
              gnt_valid <= 1'b0;
              hold_reg  <= 8'd0;
            end
          end else begin
            hold_reg <= hold_reg + 8'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
          gnt       <= 16'd0;
          gnt_valid <= 1'b0;
        end
      endcase
    end
  end

  // Data mux: the owner's lane while a grant is active, otherwise zero.
  assign out = gnt_valid ? d[sel] : 1'b0;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Bench for mux16_rr_arbiter: directed scenarios plus random traffic, each
// cycle compared against a behavioural round-robin model.
module tb_mux16_rr_arbiter;

  localparam int MAX_HOLD = 8;

  logic        clk;
  logic        rst_n;
  logic [15:0] req;
  logic [15:0] d;
  logic [15:0] gnt;
  logic        gnt_valid;
  logic [3:0]  sel;
  logic        out;

  int checks = 0;
  int fails  = 0;
  int steps  = 0;

  // Behavioural model: owner = -1 when idle; held = cycles the owner has had the grant.
  int m_owner;
  int m_ptr;
  int m_held;
  int m_sel;

  mux16_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .d(d),
    .gnt(gnt),
    .gnt_valid(gnt_valid),
    .sel(sel),
    .out(out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int find_from(input int start, input logic [15:0] r);
    for (int k = 0; k < 16; k++) begin
      if (r[(start + k) % 16]) return (start + k) % 16;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_held  = 0;
    m_sel   = 0;
  endtask

  task automatic model_edge(input logic [15:0] r);
    int w;
    if (m_owner < 0) begin
      w = find_from(m_ptr, r);
      if (w >= 0) begin
        m_owner = w; m_sel = w; m_held = 1;
      end
    end else if (!r[m_owner] || m_held == MAX_HOLD) begin
      m_ptr = (m_owner + 1) % 16;
      w = find_from(m_ptr, r);
      if (w >= 0) begin
        m_owner = w; m_sel = w; m_held = 1;
      end else begin
        m_owner = -1;
      end
    end else begin
      m_held++;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [15:0] e_gnt;
    logic        e_valid;
    logic [3:0]  e_sel;
    logic        e_out;
    e_valid = (m_owner >= 0);
    e_gnt   = e_valid ? (16'd1 << m_owner) : 16'd0;
    e_sel   = 4'(m_sel);
    e_out   = e_valid ? d[m_sel] : 1'b0;
    checks++;
    assert (gnt === e_gnt) else begin
      fails++; $error("FAIL %s gnt: got %h expected %h", tag, gnt, e_gnt);
    end
    checks++;
    assert (gnt_valid === e_valid) else begin
      fails++; $error("FAIL %s gnt_valid: got %0b expected %0b", tag, gnt_valid, e_valid);
    end
    checks++;
    assert (sel === e_sel) else begin
      fails++; $error("FAIL %s sel: got %0d expected %0d", tag, sel, e_sel);
    end
    checks++;
    assert (out === e_out) else begin
      fails++; $error("FAIL %s out: got %0b expected %0b", tag, out, e_out);
    end
  endtask

  // One clock of traffic: drive at negedge, model the posedge, check after it,
  // then wiggle d to confirm the mux output follows it without a clock.
  task automatic step(input logic [15:0] r, input logic [15:0] dv, input string tag);
    @(negedge clk);
    req = r;
    d   = dv;
    @(posedge clk);
    model_edge(r);
    #1;
    check_outputs(tag);
    steps++;
    $display("step %0d %s req=%h d=%h gnt=%h sel=%0d valid=%0b out=%0b",
             steps, tag, req, d, gnt, sel, gnt_valid, out);
    d = 16'($urandom);
    #1;
    check_outputs({tag, "_dmux"});
  endtask

  // Asynchronous reset pulse between edges; outputs must clear immediately,
  // and the first edge after release with req==0 must not grant.
  task automatic reset_pulse(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs({tag, "_async"});
    @(negedge clk);
    req   = 16'd0;
    rst_n = 1'b1;
    @(posedge clk);
    model_edge(16'd0);
    #1;
    check_outputs({tag, "_release"});
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 16'd0;
    d     = 16'd0;
    model_reset();
    #1;
    check_outputs("por");
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester held: continuous re-grant across hold expiry.
    for (int i = 0; i < 20; i++) step(16'h0001, 16'hFFFF, "solo0");
    reset_pulse("rst_a");

    // Two requesters at the ends: alternating 0 and 15 with wrap.
    for (int i = 0; i < 40; i++) step(16'h8001, 16'(i * 16'h1357), "pair_0_15");
    reset_pulse("rst_b");

    // Release by dropping request, then pointer ordering after release.
    for (int i = 0; i < 3; i++) step(16'h0010, 16'hAAAA, "lane4");
    step(16'h0000, 16'hAAAA, "drop4");
    for (int i = 0; i < 4; i++) step(16'h0021, 16'hAAAA, "ptr5");
    reset_pulse("rst_c");

    // Late request does not disturb the owner; handover when owner drops.
    for (int i = 0; i < 3; i++) step(16'h0008, 16'h00FF, "own3");
    for (int i = 0; i < 3; i++) step(16'h0088, 16'h00FF, "own3_r7");
    for (int i = 0; i < 3; i++) step(16'h0080, 16'h00FF, "hand7");
    reset_pulse("rst_d");

    // Reset mid-grant on requester 9, then pointer restarts at 0.
    for (int i = 0; i < 3; i++) step(16'h0200, 16'h0200, "own9");
    reset_pulse("rst_mid");
    for (int i = 0; i < 4; i++) step(16'h0600, 16'h0600, "post_rst");
    reset_pulse("rst_e");

    // Everyone requesting: full rotation, MAX_HOLD cycles each.
    for (int i = 0; i < 16 * MAX_HOLD + 10; i++) step(16'hFFFF, 16'(i), "all");

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) reset_pulse("rst_rand");
      step(16'($urandom & $urandom & $urandom), 16'($urandom), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
